// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory port controller.
// Access sizes, FSM states, port identifiers and the alignment rule.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RMW_RD,
    S_RMW_WR,
    S_ACK_ONLY
  } state_e;

  typedef enum logic {
    PORT_D  = 1'b0,
    PORT_IF = 1'b1
  } port_e;

  // True for any access that must complete with an error and no memory cycle.
  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_port_ctrl_if.sv
// Core-side fetch and load/store handshake bundle of the data-memory controller.
// master = CPU core, slave = dmem_port_ctrl.
interface dmem_port_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  if_rdata, if_ack, d_rdata, d_ack, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output if_rdata, if_ack, d_rdata, d_ack, d_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension and
// sub-word store merging into a full memory word (little-endian lanes).
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        zext,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = rd_word[{lane, 3'b000} +: 8];
    h        = rd_word[{lane[1], 4'b0000} +: 16];
    ext_data = rd_word;
    merged   = rd_word;
    case (size)
      SZ_BYTE: begin
        ext_data = {{24{~zext & b[7]}}, b};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ext_data = {{16{~zext & h[15]}}, h};
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Shares one single-port word memory between instruction fetch and load/store,
// with round-robin arbitration and read-modify-write for sub-word stores.
module dmem_port_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_AW        = 12,
  parameter bit          RESET_LAST_IF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_port_ctrl_if.slave   cpu,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state, state_nx;
  port_e             sel_q, sel_nx;
  logic              last_if, last_if_nx;
  logic [MEM_AW-1:0] addr_q, addr_nx;

  logic              if_ack_nx, d_ack_nx, d_err_nx;
  logic [31:0]       if_rdata_nx, d_rdata_nx;

  logic              if_rq, d_rq, grant_if;
  logic              re_c, we_c;
  logic [MEM_AW-1:0] addr_c;
  logic [31:0]       wdata_c;

  size_e             dsize;
  logic [31:0]       ext_data, merged;
  logic              unused_addr_bits;

  assign dsize = size_e'(cpu.d_size);
  assign unused_addr_bits = ^{cpu.if_addr[31:MEM_AW+2], cpu.if_addr[1:0],
                              cpu.d_addr[31:MEM_AW+2]};

  dmem_lane_align u_align (
    .rd_word  (mem_rdata),
    .lane     (cpu.d_addr[1:0]),
    .size     (dsize),
    .zext     (cpu.d_unsigned),
    .wdata    (cpu.d_wdata),
    .ext_data (ext_data),
    .merged   (merged)
  );

  // A port acking this cycle is masked so it cannot be regranted back-to-back.
  assign if_rq = cpu.if_req & ~cpu.if_ack;
  assign d_rq  = cpu.d_req  & ~cpu.d_ack;

  always_comb begin
    state_nx    = state;
    sel_nx      = sel_q;
    last_if_nx  = last_if;
    addr_nx     = addr_q;
    if_ack_nx   = 1'b0;
    d_ack_nx    = 1'b0;
    d_err_nx    = 1'b0;
    if_rdata_nx = cpu.if_rdata;
    d_rdata_nx  = cpu.d_rdata;
    addr_c      = addr_q;
    re_c        = 1'b0;
    we_c        = 1'b0;
    wdata_c     = merged;
    grant_if    = 1'b0;

    case (state)
      S_IDLE: begin
        if (if_rq || d_rq) begin
          grant_if   = if_rq && (!d_rq || !last_if);
          last_if_nx = grant_if;
          if (grant_if) begin
            sel_nx   = PORT_IF;
            addr_c   = cpu.if_addr[MEM_AW+1:2];
            re_c     = 1'b1;
            state_nx = S_RD_WAIT;
          end else begin
            sel_nx = PORT_D;
            addr_c = cpu.d_addr[MEM_AW+1:2];
            // Acks are registered, so single-cycle completions raise them here.
            if (misaligned(dsize, cpu.d_addr[1:0])) begin
              d_ack_nx = 1'b1;
              d_err_nx = 1'b1;
              state_nx = S_ACK_ONLY;
            end else if (!cpu.d_we) begin
              re_c     = 1'b1;
              state_nx = S_RD_WAIT;
            end else if (dsize == SZ_WORD) begin
              we_c     = 1'b1;
              wdata_c  = cpu.d_wdata;
              d_ack_nx = 1'b1;
              state_nx = S_ACK_ONLY;
            end else begin
              re_c     = 1'b1;
              state_nx = S_RMW_RD;
            end
          end
          addr_nx = addr_c;
        end
      end
      S_RD_WAIT: begin
        if (sel_q == PORT_IF) begin
          if_rdata_nx = mem_rdata;
          if_ack_nx   = 1'b1;
        end else begin
          d_rdata_nx = ext_data;
          d_ack_nx   = 1'b1;
        end
        state_nx = S_IDLE;
      end
      S_RMW_RD: begin
        we_c     = 1'b1;
        wdata_c  = merged;
        d_ack_nx = 1'b1;
        state_nx = S_RMW_WR;
      end
      S_RMW_WR, S_ACK_ONLY: state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
  end

  // Strobes are gated so a held request cannot touch memory during reset.
  assign mem_addr  = addr_c;
  assign mem_re    = re_c & rst_n;
  assign mem_we    = we_c & rst_n;
  assign mem_wdata = wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sel_q        <= PORT_D;
      last_if      <= RESET_LAST_IF;
      addr_q       <= '0;
      cpu.if_ack   <= 1'b0;
      cpu.d_ack    <= 1'b0;
      cpu.d_err    <= 1'b0;
      cpu.if_rdata <= '0;
      cpu.d_rdata  <= '0;
    end else begin
      state        <= state_nx;
      sel_q        <= sel_nx;
      last_if      <= last_if_nx;
      addr_q       <= addr_nx;
      cpu.if_ack   <= if_ack_nx;
      cpu.d_ack    <= d_ack_nx;
      cpu.d_err    <= d_err_nx;
      cpu.if_rdata <= if_rdata_nx;
      cpu.d_rdata  <= d_rdata_nx;
    end
  end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Scoreboard bench for dmem_port_ctrl: directed timing cases plus randomized
// concurrent fetch/data traffic checked against a byte-level memory model.
module tb_dmem_port_ctrl;

  typedef struct packed {
    logic        chk;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_port_ctrl_if bus();

  dmem_port_ctrl #(.MEM_AW(12), .RESET_LAST_IF(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (bus),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  bit          loaded = 1'b0;
  int          cyc = 0;

  int vectors = 0, miscompares = 0;
  int re_cnt = 0, we_cnt = 0, re_cyc = -1, we_cyc = -1;
  logic [31:0] we_data = '0;
  exp_t        d_q[$];
  logic [31:0] f_q[$];
  int          ack_log[$];
  bit          log_en = 1'b0;

  function automatic logic [31:0] pat(input int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  function automatic bit ref_err(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * lo[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    if (sz == 2'd2) return wd;
    sh   = (sz == 2'd0) ? 8 * lo : 16 * lo[1];
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory array model: synchronous read, whole-word write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Monitor: pops the scoreboard whenever an ack is presented.
  initial begin
    exp_t        e;
    logic [31:0] hold_d, hold_f;
    int          d_last, f_last;
    hold_d = '0; hold_f = '0; d_last = -10; f_last = -10;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_d = '0; hold_f = '0; d_last = -10; f_last = -10;
      end else begin
        if (mem_re) begin re_cnt++; re_cyc = cyc; end
        if (mem_we) begin we_cnt++; we_cyc = cyc; we_data = mem_wdata; end
        if (bus.if_ack || bus.d_ack)
          check("ack_exclusive", {31'b0, bus.if_ack & bus.d_ack}, 32'd0);
        if (bus.if_ack) begin
          if (log_en) ack_log.push_back(1);
          if (f_q.size() == 0) check("if_unexpected_ack", 32'd1, 32'd0);
          else begin
            hold_f = f_q.pop_front();
            check("if_rdata", bus.if_rdata, hold_f);
          end
          f_last = cyc;
        end else if (cyc == f_last + 1) begin
          check("if_rdata_hold", bus.if_rdata, hold_f);
        end
        if (bus.d_ack) begin
          if (log_en) ack_log.push_back(0);
          if (d_q.size() == 0) check("d_unexpected_ack", 32'd1, 32'd0);
          else begin
            e = d_q.pop_front();
            check("d_err", {31'b0, bus.d_err}, {31'b0, e.err});
            if (e.chk) begin
              check("d_rdata", bus.d_rdata, e.data);
              hold_d = e.data;
            end
          end
          d_last = cyc;
        end else if (cyc == d_last + 1) begin
          check("d_rdata_hold", bus.d_rdata, hold_d);
        end
      end
    end
  end

  task automatic wait_ack(input bit is_f, input int t0, output int lat);
    lat = -1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (is_f ? bus.if_ack : bus.d_ack) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no ack, expected ack within 24 cycles", is_f ? "if" : "d");
    end
  endtask

  task automatic d_access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int t_iss, output int lat);
    exp_t        e;
    int          w;
    logic [31:0] old;
    bit          err;
    w      = int'(addr[13:2]);
    old    = ref_mem[w];
    err    = ref_err(sz, addr[1:0]);
    e.err  = err;
    e.chk  = !we && !err;
    e.data = ref_load(old, addr[1:0], sz, uns);
    if (we && !err) ref_mem[w] = ref_store(old, addr[1:0], sz, wd);
    d_q.push_back(e);
    @(posedge clk); #1;
    bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
    bus.d_addr = addr; bus.d_wdata = wd; bus.d_req = 1'b1;
    t_iss = cyc;
    wait_ack(1'b0, t_iss, lat);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  task automatic f_access(input logic [31:0] addr, output int t_iss, output int lat);
    f_q.push_back(ref_mem[int'(addr[13:2])]);
    @(posedge clk); #1;
    bus.if_addr = addr; bus.if_req = 1'b1;
    t_iss = cyc;
    wait_ack(1'b1, t_iss, lat);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, l, r0, w0, t0;
    logic [31:0] a;
    exp_t e;

    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_unsigned = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;

    // Requests held during reset must not reach memory.
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", {31'b0, bus.if_ack}, 32'd0);
    check("rst_d_ack", {31'b0, bus.d_ack}, 32'd0);
    check("rst_d_err", {31'b0, bus.d_err}, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0; rst_n = 1'b1;

    // Simultaneous requesters after reset: data wins first, then strict alternation.
    log_en = 1'b1;
    fork
      begin
        int tt, ll;
        for (int k = 0; k < 3; k++) d_access(1'b0, 2'd2, 1'b0, 32'(4 + k) << 2, '0, tt, ll);
      end
      begin
        int tt, ll;
        for (int k = 0; k < 3; k++) f_access(32'(1 + k) << 2, tt, ll);
      end
    join
    log_en = 1'b0;
    check("grant_count", ack_log.size(), 32'd6);
    for (int k = 0; k < 6 && k < ack_log.size(); k++)
      check("grant_order", ack_log[k], (k % 2 == 0) ? 32'd0 : 32'd1);

    // Directed loads from word 0x10 = 0x8899AABB.
    r0 = re_cnt;
    d_access(1'b0, 2'd0, 1'b0, 32'h13, '0, t, l);
    check("lb_latency", l, 32'd2);
    check("lb_mem_re", re_cnt - r0, 32'd1);
    d_access(1'b0, 2'd0, 1'b1, 32'h13, '0, t, l);
    check("lbu_latency", l, 32'd2);
    d_access(1'b0, 2'd1, 1'b0, 32'h12, '0, t, l);
    check("lh_latency", l, 32'd2);
    d_access(1'b0, 2'd1, 1'b1, 32'h0000_4010, '0, t, l);
    check("lhu_alias_latency", l, 32'd2);

    // Misaligned and reserved accesses: error ack at T+1, no memory cycle.
    r0 = re_cnt; w0 = we_cnt;
    d_access(1'b0, 2'd1, 1'b0, 32'h11, '0, t, l);
    check("lh_mis_latency", l, 32'd1);
    d_access(1'b0, 2'd2, 1'b0, 32'h12, '0, t, l);
    check("lw_mis_latency", l, 32'd1);
    d_access(1'b1, 2'd3, 1'b0, 32'h10, 32'h1234_5678, t, l);
    check("rsvd_latency", l, 32'd1);
    check("err_no_mem_re", re_cnt - r0, 32'd0);
    check("err_no_mem_we", we_cnt - w0, 32'd0);

    // Byte store read-modify-write.
    r0 = re_cnt; w0 = we_cnt;
    d_access(1'b1, 2'd0, 1'b0, 32'h11, 32'h5C, t, l);
    check("sb_latency", l, 32'd2);
    check("sb_re_cycle", re_cyc, t);
    check("sb_we_cycle", we_cyc, t + 1);
    check("sb_wdata", we_data, ref_mem[4]);
    check("sb_we_count", we_cnt - w0, 32'd1);
    check("sb_re_count", re_cnt - r0, 32'd1);
    d_access(1'b0, 2'd2, 1'b0, 32'h10, '0, t, l);

    // Word store then a fetch of the same word.
    d_access(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, t, l);
    check("sw_latency", l, 32'd1);
    check("sw_we_cycle", we_cyc, t);
    check("sw_wdata", we_data, ref_mem[8]);
    f_access(32'h20, t, l);
    check("if_latency", l, 32'd2);

    // Reset asserted during the RMW_RD cycle of a byte store, request held.
    a = 32'h0000_00A1;
    w0 = we_cnt;
    @(posedge clk); #1;
    bus.d_we = 1'b1; bus.d_size = 2'd0; bus.d_unsigned = 1'b0;
    bus.d_addr = a; bus.d_wdata = 32'h3C; bus.d_req = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_d_ack", {31'b0, bus.d_ack}, 32'd0);
    check("mid_rst_d_err", {31'b0, bus.d_err}, 32'd0);
    check("mid_rst_if_ack", {31'b0, bus.if_ack}, 32'd0);
    check("mid_rst_d_rdata", bus.d_rdata, 32'd0);
    check("mid_rst_if_rdata", bus.if_rdata, 32'd0);
    check("mid_rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_write", mem[40], ref_mem[40]);
    check("mid_rst_we_count", we_cnt - w0, 32'd0);
    @(posedge clk); #1;
    e.err = 1'b0; e.chk = 1'b0; e.data = '0;
    ref_mem[40] = ref_store(ref_mem[40], a[1:0], 2'd0, 32'h3C);
    d_q.push_back(e);
    rst_n = 1'b1;
    t0 = cyc;
    wait_ack(1'b0, t0, l);
    check("reissue_latency", l, 32'd2);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    d_access(1'b0, 2'd2, 1'b0, 32'h0000_00A0, '0, t, l);

    // Randomized concurrent traffic: data owns words 32..63, fetch reads 0..31.
    fork
      begin
        int tt, ll;
        logic [31:0] ra;
        for (int k = 0; k < 150; k++) begin
          ra = ($urandom & 32'hFFFF_C000) | (32'(32 + $urandom_range(0, 31)) << 2)
             | 32'($urandom_range(0, 3));
          d_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, $urandom, tt, ll);
        end
      end
      begin
        int tt, ll;
        logic [31:0] fa;
        for (int k = 0; k < 100; k++) begin
          fa = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2)
             | 32'($urandom_range(0, 3));
          f_access(fa, tt, ll);
          if ($urandom_range(0, 1) == 1) @(posedge clk);
        end
      end
    join

    repeat (4) @(posedge clk);
    check("d_queue_drained", d_q.size(), 32'd0);
    check("if_queue_drained", f_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
